instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Datapath front end of the multicycle 8-bit MIPS core, sitting beside the control FSM (statelogic).
- Takes the FSM's 6-bit state and assembles each 32-bit instruction from four byte reads into the instruction register (IR).
- Returns `op` to the FSM and decoded fields to the register file and ALU.
- Owns the PC: sequential increment, branch-target latch, branch/jump update. Also drives the memory address, read and write strobes.

Parameters:
- WIDTH, 8, datapath/PC/address width in bits.
- PC_RESET, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- state  input  6  current control state from statelogic.
- memdata  input  WIDTH  memory read data; asynchronous read, valid in the same cycle as `adr`.
- data_adr  input  WIDTH  ALU result used as data address in LBRD/SBWR.
- zero  input  1  ALU zero flag, sampled in BEQEX.
- adr  output  WIDTH  memory address.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- op  output  6  ir[31:26].
- funct  output  6  ir[5:0].
- rs, rt, rd  output  5 each  ir[25:21], ir[20:16], ir[15:11].
- imm  output  WIDTH  ir[WIDTH-1:0].
- pc  output  WIDTH  current PC.
- instr_valid  output  1  IR holds a complete instruction.

Behaviour:
- State encodings: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12.
- Reset (reset==0 at posedge): pc=PC_RESET, ir=0, btarget=0, instr_valid=0. Resulting outputs: op/funct/rs/rt/rd/imm=0.
- Reset takes effect in any state, including mid-fetch. Partially loaded IR bytes are discarded.
- adr/memread/memwrite are combinational from state. They are driven even during reset.
- FETCHk (k=1..4):
  - adr=pc, memread=1.
  - At posedge: ir byte k-1 <= memdata (little-endian: FETCH1 loads ir[7:0], FETCH4 loads ir[31:24]).
  - pc <= pc+1, modulo 2^WIDTH (0xFF+1 -> 0x00).
  - Other IR bytes are held.
- instr_valid:
  - Cleared at the posedge ending FETCH1.
  - Set at the posedge ending FETCH4.
  - Otherwise held.
- DECODE: btarget <= pc + {ir[5:0],2'b00}, truncated to WIDTH, wrapping. pc is held.
- LBRD: adr=data_adr, memread=1.
- SBWR: adr=data_adr, memwrite=1.
- BEQEX: if zero==1, pc <= btarget; else pc is held.
- JEX: pc <= {ir[5:0],2'b00}.
- All other states, including the illegal codes 13..63:
  - adr=pc, memread=0, memwrite=0.
  - No register updates.
- memread and memwrite are never both 1.
- IR changes only in FETCH states, so op/fields are stable from DECODE to the end of the instruction.

Optional Feature:
- INSTR_PC_EN defined:
  - Adds output `instr_pc` [WIDTH-1:0].
  - Loaded with pc at the posedge ending FETCH1 (the address of byte 0 of the current instruction).
  - Reset value PC_RESET.
  - Used for trace and debug.
- INSTR_PC_EN undefined: the port and the register are absent. All other behaviour is identical.

Decomposition:
- Shared package `mips_pkg`: state encodings (FETCH1..JEX), opcode constants (LB=6'h20, SB=6'h28, RTYPE=0, BEQ=4, J=2), IR field bit positions. statelogic uses the same package.
- Sub-module `pc_reg`: PC register with increment, branch-target latch, and branch/jump select. It keeps PC arithmetic separately testable. IR assembly and address muxing stay in the top.

Test Plan:
- Reset then fetch bytes 44,00,02,80 during states 0..3:
  - ir=0x80020044, op=6'h20, rt=2, imm=0x44.
  - pc 0x00 -> 0x04.
  - instr_valid rises after FETCH4; memread=1 in each fetch cycle.
- Fetch 0x10000003 from pc=0, then DECODE, then BEQEX:
  - btarget=0x10.
  - zero=1 gives pc=0x10; zero=0 leaves pc=0x04.
- Fetch 0x08000005, then JEX: pc=0x14.
- MEMADR -> LBRD -> LBWR with data_adr=0x44:
  - LBRD: adr=0x44, memread=1, memwrite=0.
  - SBWR with data_adr=0x50: adr=0x50, memwrite=1, memread=0.
- pc wrap: start at pc=0xFE, run 4 fetch states -> pc=0x02.
  - DECODE with ir[5:0]=0x3F: btarget=(0x02+0xFC)&0xFF=0xFE.
- Drive reset=0 during FETCH3 after two bytes loaded:
  - Next cycle: ir=0, pc=PC_RESET, instr_valid=0, op=0.
  - State code 13 afterwards: no pc/ir change, memread=memwrite=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle 8-bit MIPS core: control state
// encodings, opcodes and instruction-register field positions.
package mips_pkg;

  typedef enum logic [5:0] {
    FETCH1  = 6'd0,
    FETCH2  = 6'd1,
    FETCH3  = 6'd2,
    FETCH4  = 6'd3,
    DECODE  = 6'd4,
    MEMADR  = 6'd5,
    LBRD    = 6'd6,
    LBWR    = 6'd7,
    SBWR    = 6'd8,
    RTYPEEX = 6'd9,
    RTYPEWR = 6'd10,
    BEQEX   = 6'd11,
    JEX     = 6'd12
  } state_t;

  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  function automatic logic is_fetch(input logic [5:0] s);
    return s inside {FETCH1, FETCH2, FETCH3, FETCH4};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: sequential increment during fetch, branch-target latch in
// DECODE, conditional branch in BEQEX and absolute jump in JEX.
module pc_reg
  import mips_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       state,
  input  logic [5:0]       offset,
  input  logic             zero,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q, pc_next;
  logic [WIDTH-1:0] btarget_q, btarget_next;
  logic [WIDTH-1:0] word_offset;

  // Word offset and jump target share the same shifted field, wrapping at WIDTH.
  assign word_offset = WIDTH'({offset, 2'b00});

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    pc_next      = pc_q;
    btarget_next = btarget_q;
    case (state_t'(state))
      FETCH1, FETCH2, FETCH3, FETCH4: pc_next = pc_q + WIDTH'(1);
      DECODE:                          btarget_next = pc_q + word_offset;
      BEQEX:                           if (zero) pc_next = btarget_q;
      JEX:                             pc_next = word_offset;
      default:                         ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= PC_RESET;
      btarget_q <= '0;
    end else begin
      pc_q      <= pc_next;
      btarget_q <= btarget_next;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Datapath front end: assembles the 32-bit IR from four byte fetches, drives
// memory address/strobes and owns the PC. Define INSTR_PC_EN for the instr_pc trace port.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       state,
  input  logic [WIDTH-1:0] memdata,
  input  logic [WIDTH-1:0] data_adr,
  input  logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic             memread,
  output logic             memwrite,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] pc,
  output logic             instr_valid
`ifdef INSTR_PC_EN
  ,
  output logic [WIDTH-1:0] instr_pc
`endif
);

  logic [31:0] ir;
  logic        unused_ir;

  pc_reg #(
    .WIDTH    (WIDTH),
    .PC_RESET (PC_RESET)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .state  (state),
    .offset (ir[FUNCT_HI:FUNCT_LO]),
    .zero   (zero),
    .pc     (pc)
  );

  // Little-endian assembly: the low two state bits select the IR byte lane.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir          <= '0;
      instr_valid <= 1'b0;
    end else if (is_fetch(state)) begin
      ir[8*state[1:0] +: 8] <= memdata[7:0];
      if (state == FETCH1) instr_valid <= 1'b0;
      if (state == FETCH4) instr_valid <= 1'b1;
    end
  end

`ifdef INSTR_PC_EN
  always_ff @(posedge clk) begin
    if (!reset)                instr_pc <= PC_RESET;
    else if (state == FETCH1)  instr_pc <= pc;
  end
`endif

  always_comb begin
    adr      = pc;
    memread  = 1'b0;
    memwrite = 1'b0;
    case (state_t'(state))
      FETCH1, FETCH2, FETCH3, FETCH4: memread = 1'b1;
      LBRD: begin
        adr     = data_adr;
        memread = 1'b1;
      end
      SBWR: begin
        adr      = data_adr;
        memwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign op        = ir[OP_HI:OP_LO];
  assign rs        = ir[RS_HI:RS_LO];
  assign rt        = ir[RT_HI:RT_LO];
  assign rd        = ir[RD_HI:RD_LO];
  assign funct     = ir[FUNCT_HI:FUNCT_LO];
  assign imm       = ir[WIDTH-1:0];
  assign unused_ir = ^ir[10:8];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: fetch assembly, branch,
// jump, memory address muxing, PC wrap and mid-fetch reset.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic [5:0] state;
  logic [7:0] memdata;
  logic [7:0] data_adr;
  logic       zero;
  logic [7:0] adr;
  logic       memread;
  logic       memwrite;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs, rt, rd;
  logic [7:0] imm;
  logic [7:0] pc;
  logic       instr_valid;
`ifdef INSTR_PC_EN
  logic [7:0] instr_pc;
`endif

  int passed = 0;
  int total  = 0;
  logic [7:0] model_pc;

  instr_fetch_unit #(.WIDTH(8), .PC_RESET(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .memdata     (memdata),
    .data_adr    (data_adr),
    .zero        (zero),
    .adr         (adr),
    .memread     (memread),
    .memwrite    (memwrite),
    .op          (op),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .pc          (pc),
    .instr_valid (instr_valid)
`ifdef INSTR_PC_EN
    ,
    .instr_pc    (instr_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] st, input logic [7:0] md);
    state   = st;
    memdata = md;
    #1;
  endtask

  // Four fetch cycles with per-cycle strobe, address and PC checks.
  task automatic fetch_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      drive(6'(k), w[8*k +: 8]);
      check("fetch_memread", {31'd0, memread}, 32'd1);
      check("fetch_adr", {24'd0, adr}, {24'd0, model_pc});
      tick();
      model_pc = model_pc + 8'd1;
      check("fetch_pc", {24'd0, pc}, {24'd0, model_pc});
    end
  endtask

  initial begin
    reset    = 1'b0;
    state    = 6'd0;
    memdata  = 8'hAA;
    data_adr = 8'h00;
    zero     = 1'b0;
    #1;
    tick();
    tick();

    // Reset state; address/strobes stay driven during reset.
    check("rst_pc", {24'd0, pc}, 32'h00);
    check("rst_op", {26'd0, op}, 32'h00);
    check("rst_imm", {24'd0, imm}, 32'h00);
    check("rst_funct", {26'd0, funct}, 32'h00);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_memread", {31'd0, memread}, 32'd1);
    check("rst_adr", {24'd0, adr}, 32'h00);

    // LB instruction 0x80020044.
    reset    = 1'b1;
    model_pc = 8'h00;
    drive(6'd0, 8'h44);
    check("f1_memwrite", {31'd0, memwrite}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(6'(k), (k == 0) ? 8'h44 : (k == 1) ? 8'h00 : (k == 2) ? 8'h02 : 8'h80);
      check("lb_memread", {31'd0, memread}, 32'd1);
      check("lb_adr", {24'd0, adr}, {24'd0, model_pc});
      tick();
      model_pc = model_pc + 8'd1;
      if (k == 2) check("lb_valid_before_f4", {31'd0, instr_valid}, 32'd0);
    end
    check("lb_pc", {24'd0, pc}, 32'h04);
    check("lb_valid", {31'd0, instr_valid}, 32'd1);
    check("lb_op", {26'd0, op}, 32'h20);
    check("lb_rt", {27'd0, rt}, 32'd2);
    check("lb_rs", {27'd0, rs}, 32'd0);
    check("lb_rd", {27'd0, rd}, 32'd0);
    check("lb_imm", {24'd0, imm}, 32'h44);
    check("lb_funct", {26'd0, funct}, 32'h04);

    // BEQ 0x10000003 from pc=0: btarget = 4 + 12 = 0x10.
    reset = 1'b0;
    drive(6'd13, 8'h00);
    tick();
    reset    = 1'b1;
    model_pc = 8'h00;
    fetch_word(32'h10000003);
    drive(6'd4, 8'h00);
    tick();
    check("dec_pc_held", {24'd0, pc}, 32'h04);
    check("beq_op", {26'd0, op}, 32'h04);
    zero = 1'b0;
    drive(6'd11, 8'h00);
    tick();
    check("beq_nt_pc", {24'd0, pc}, 32'h04);
    zero = 1'b1;
    drive(6'd11, 8'h00);
    tick();
    check("beq_t_pc", {24'd0, pc}, 32'h10);
    zero = 1'b0;

    // J 0x08000005 from pc=0: target 0x14.
    reset = 1'b0;
    drive(6'd13, 8'h00);
    tick();
    reset    = 1'b1;
    model_pc = 8'h00;
    fetch_word(32'h08000005);
    check("j_op", {26'd0, op}, 32'h02);
    drive(6'd12, 8'h00);
    tick();
    check("jex_pc", {24'd0, pc}, 32'h14);

    // Memory address muxing.
    data_adr = 8'h44;
    drive(6'd5, 8'h00);
    check("memadr_adr", {24'd0, adr}, 32'h14);
    check("memadr_memread", {31'd0, memread}, 32'd0);
    tick();
    drive(6'd6, 8'h00);
    check("lbrd_adr", {24'd0, adr}, 32'h44);
    check("lbrd_memread", {31'd0, memread}, 32'd1);
    check("lbrd_memwrite", {31'd0, memwrite}, 32'd0);
    tick();
    drive(6'd7, 8'h00);
    check("lbwr_memread", {31'd0, memread}, 32'd0);
    check("lbwr_adr", {24'd0, adr}, 32'h14);
    tick();
    data_adr = 8'h50;
    drive(6'd8, 8'h00);
    check("sbwr_adr", {24'd0, adr}, 32'h50);
    check("sbwr_memwrite", {31'd0, memwrite}, 32'd1);
    check("sbwr_memread", {31'd0, memread}, 32'd0);
    tick();
    check("mem_pc_held", {24'd0, pc}, 32'h14);

    // Illegal state code holds everything.
    drive(6'd13, 8'hFF);
    check("ill_memread", {31'd0, memread}, 32'd0);
    check("ill_memwrite", {31'd0, memwrite}, 32'd0);
    tick();
    check("ill_pc", {24'd0, pc}, 32'h14);
    check("ill_imm", {24'd0, imm}, 32'h05);

    // Jump to 0xFC, advance to 0xFE, then fetch across the wrap.
    model_pc = 8'h14;
    drive(6'd0, 8'h3F);
    tick();
    check("f1_clears_valid", {31'd0, instr_valid}, 32'd0);
    model_pc = 8'h15;
    for (int k = 1; k < 4; k++) begin
      drive(6'(k), (k == 3) ? 8'h08 : 8'h00);
      tick();
    end
    check("j3f_valid", {31'd0, instr_valid}, 32'd1);
    drive(6'd12, 8'h00);
    tick();
    check("jex_fc", {24'd0, pc}, 32'hFC);
    drive(6'd0, 8'hAA);
    tick();
    drive(6'd1, 8'hBB);
    tick();
    check("pc_fe", {24'd0, pc}, 32'hFE);
    model_pc = 8'hFE;
    fetch_word(32'h3322113F);
    check("wrap_pc", {24'd0, pc}, 32'h02);
    check("wrap_funct", {26'd0, funct}, 32'h3F);
    drive(6'd4, 8'h00);
    tick();
    zero = 1'b1;
    drive(6'd11, 8'h00);
    tick();
    check("wrap_btarget", {24'd0, pc}, 32'hFE);
    zero = 1'b0;

    // Reset during FETCH3 after two bytes loaded (pc 0xFE -> 0x00).
    drive(6'd0, 8'h11);
    tick();
    drive(6'd1, 8'h22);
    tick();
    check("mid_pc", {24'd0, pc}, 32'h00);
    reset = 1'b0;
    drive(6'd2, 8'h33);
    check("mid_rst_memread", {31'd0, memread}, 32'd1);
    tick();
    check("mid_rst_op", {26'd0, op}, 32'h00);
    check("mid_rst_imm", {24'd0, imm}, 32'h00);
    check("mid_rst_funct", {26'd0, funct}, 32'h00);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_pc", {24'd0, pc}, 32'h00);
    reset = 1'b1;
    drive(6'd13, 8'h77);
    check("post_ill_memread", {31'd0, memread}, 32'd0);
    check("post_ill_memwrite", {31'd0, memwrite}, 32'd0);
    tick();
    check("post_ill_pc", {24'd0, pc}, 32'h00);
    check("post_ill_imm", {24'd0, imm}, 32'h00);
    drive(6'd63, 8'h77);
    check("ill63_memread", {31'd0, memread}, 32'd0);
    tick();
    check("ill63_pc", {24'd0, pc}, 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
